nvm_shadow: RTL and testbench
=============================

NVM_SHADOW -- requirements
Module: nvm_shadow

Interface
REQ-001 The module SHALL have these parameters:
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W; legal 6..8.
- MAC_OUI, 24'hEC3F05, MAC upper 24 bits.
- ICW1, 16'h6000, init value for word 0x0A.
- SUB_PID, 16'h6120, init value for word 0x0B.
- SUB_VID, 16'hFACE, init value for word 0x0C.
- PID, 16'h3B00, init value for word 0x0D.
- VID, 16'h0706, init value for word 0x0E.
- ICW2, 16'h1000, init value for word 0x0F.
- BAMSO, 16'h8000, init value for word 0x30.
- CSUM_TARGET, 16'hBABA, required 16-bit sum of all words.

REQ-002 The module SHALL have these ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-low reset.
- id  in  57  device DNA.
- id_valid  in  1  id stable.
- rd_req  in  1  read request, level, held until ack.
- rd_addr  in  8  word address.
- rd_ack  out  1  one-cycle pulse.
- rd_data  out  16  valid in the rd_ack cycle.
- wr_req  in  1  write request, level, held until ack.
- wr_addr  in  8  word address.
- wr_data  in  16  write word.
- wr_ack  out  1  one-cycle pulse.
- mac_address  out  48  {MAC_OUI, mac24}.
- mac_valid  out  1  MAC loaded.
- busy  out  1  state != READY.

Function
REQ-003 Storage SHALL be a DEPTH x 16 register array; word DEPTH-1 is the checksum word.
REQ-004 The FSM SHALL have states INIT, WAIT_ID, LOAD_MAC, CSUM and READY.
REQ-005 INIT SHALL write one word per cycle, address 0..DEPTH-1 (DEPTH cycles):
- word 0 = {MAC_OUI[15:8], MAC_OUI[23:16]}.
- word 1 = {8'h00, MAC_OUI[7:0]}.
- words 0x0A-0x0F and 0x30 = the corresponding parameters.
- all other words = 0.
INIT SHALL then go to WAIT_ID.
REQ-006 WAIT_ID SHALL remain until id_valid=1, then latch mac24 = (id[56:48] + id[47:24] + id[23:0]) mod 2^24 and go to LOAD_MAC.
REQ-007 LOAD_MAC SHALL take 2 cycles:
- write word 1 = {mac24[23:16], MAC_OUI[7:0]}.
- write word 2 = {mac24[7:0], mac24[15:8]}.
- set mac_valid=1.
- go to CSUM.
REQ-008 CSUM SHALL accumulate words 0..DEPTH-2, one per cycle, mod 2^16 (DEPTH-1 cycles), then write word DEPTH-1 = CSUM_TARGET - sum in one further cycle, then go to READY.
REQ-009 Later changes on id or id_valid SHALL be ignored until the next reset.
REQ-010 Reads SHALL be served only in READY:
- rd_req=1 -> next cycle rd_ack=1 with rd_data = word[rd_addr].
- rd_addr >= DEPTH -> rd_data = 16'hFFFF.
- at most one ack per two cycles, so a held rd_req is not double-acked.
REQ-011 A rd_req arriving outside READY SHALL be held pending and acked after entry to READY.
REQ-012 When rd_req and wr_req are asserted in the same READY cycle, the read SHALL win; the write waits.
REQ-013 A write (when compiled in, REQ-017) SHALL, in READY:
- store wr_data at wr_addr.
- pulse wr_ack next cycle.
- enter CSUM (full recompute, DEPTH cycles, busy=1).
REQ-014 Writes to wr_addr = DEPTH-1 or wr_addr >= DEPTH SHALL be acked but not stored, and SHALL NOT trigger CSUM.
REQ-015 busy SHALL be 1 in every state except READY.

Reset
REQ-016 On rst_i=0, asynchronously and independent of any state, the block SHALL:
- go to INIT with address counter 0.
- clear rd_ack, wr_ack and mac_valid.
- set rd_data = 0 and mac24 = 0, so mac_address = {MAC_OUI, 24'h0}.
- drop all pending requests.
On release, it SHALL restart from INIT, including when reset hits mid-CSUM.

Configuration
REQ-017 The write port SHALL be controlled by the macro NVM_SHADOW_WRITE_EN:
- defined -> write path per REQ-013/014.
- undefined -> write logic absent, wr_* inputs ignored, wr_ack tied 0, contents change only via INIT/LOAD_MAC/CSUM.

Verification
REQ-018 Reset release, id=0, id_valid=1 -> busy falls after about 2*DEPTH+3 cycles.
- Reads then give word 0 = 16'h3FEC, word 1 = 16'h0005, word 2 = 16'h0000, word 0x3F = 16'hECD5.
- mac_address = 48'hEC3F05000000.
REQ-019 id = {9'h001, 24'h000010, 24'h000100} -> mac24 = 24'h000111, word 1 = 16'h0005, word 2 = 16'h1101; sum of all 64 words = 16'hBABA.
REQ-020 With write enabled, write 0x20 = 16'h0001 after the REQ-018 setup -> wr_ack, then busy for DEPTH cycles, then word 0x3F = 16'hECD4.
REQ-021 rd_req held from reset through READY -> exactly one rd_ack, after busy falls; rd_addr=8'h80 with ADDR_W=6 -> 16'hFFFF.
REQ-022 Simultaneous rd_req/wr_req in READY -> rd_ack first, wr_ack later; write to 0x3F -> acked, word unchanged, busy stays 0.
REQ-023 Assert rst_i=0 mid-CSUM -> all outputs return to reset values immediately; full INIT sequence repeats after release.

Source files
------------

// File: rtl/nvm_shadow.sv
// nvm_shadow: 16-bit word shadow image of a config NVM (MAC, IDs, checksum) built after reset from device DNA.
// Latency: image ready 2*DEPTH+3 cycles after reset release when id_valid is already high; read ack one cycle after accept.
// Backpressure: rd_req/wr_req are level requests held until ack; held off while busy, at most one ack per two cycles per port.
//
// Optional feature: define NVM_SHADOW_WRITE_EN to compile in the write port. Without it the wr_* inputs are
// ignored, wr_ack is tied low and the image changes only through INIT, LOAD_MAC and CSUM.
//
// Ports:
//   clk_i, rst_i          single clock, asynchronous active-low reset
//   id[56:0], id_valid    device DNA; sampled once per reset when id_valid is first seen high
//   rd_req/rd_addr        level read request; rd_ack pulses with rd_data (16'hFFFF beyond DEPTH)
//   wr_req/wr_addr/wr_data level write request; wr_ack pulses one cycle after accept
//   mac_address/mac_valid {MAC_OUI, mac24} and its valid flag
//   busy                  high whenever the image is not in READY

module nvm_shadow #(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [23:0] MAC_OUI     = 24'hEC3F05,
    parameter logic [15:0] ICW1        = 16'h6000,
    parameter logic [15:0] SUB_PID     = 16'h6120,
    parameter logic [15:0] SUB_VID     = 16'hFACE,
    parameter logic [15:0] PID         = 16'h3B00,
    parameter logic [15:0] VID         = 16'h0706,
    parameter logic [15:0] ICW2        = 16'h1000,
    parameter logic [15:0] BAMSO       = 16'h8000,
    parameter logic [15:0] CSUM_TARGET = 16'hBABA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [56:0] id,
    input  logic        id_valid,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic [47:0] mac_address,
    output logic        mac_valid,
    output logic        busy
);

    localparam int unsigned       DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    // Request addresses are 8 bits wide; compare them against DEPTH in 9 bits so ADDR_W=8 works too.
    localparam logic [8:0]        DEPTH9 = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_ID,
        S_LOAD_MAC,
        S_CSUM,
        S_READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;     // word pointer, reused by INIT, LOAD_MAC and CSUM
    logic [15:0]       acc_q, acc_d;     // running checksum
    logic [23:0]       mac24_q;
    logic              latch_mac;

    logic [15:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdat;

    logic              rd_go;
    logic              rd_in_range;

    // Power-on image content for one word address.
    function automatic logic [15:0] init_word(input logic [ADDR_W-1:0] a);
        logic [7:0] a8;
        a8 = 8'(a);
        case (a8)
            8'h00:   return {MAC_OUI[15:8], MAC_OUI[23:16]};
            8'h01:   return {8'h00, MAC_OUI[7:0]};
            8'h0A:   return ICW1;
            8'h0B:   return SUB_PID;
            8'h0C:   return SUB_VID;
            8'h0D:   return PID;
            8'h0E:   return VID;
            8'h0F:   return ICW2;
            8'h30:   return BAMSO;
            default: return 16'h0000;
        endcase
    endfunction

    // Reads are only served in READY; the rd_ack term keeps a still-held request from being accepted
    // again in the ack cycle, giving at most one ack every two cycles.
    assign rd_go       = (state_q == S_READY) && rd_req && !rd_ack;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH9);

`ifdef NVM_SHADOW_WRITE_EN
    logic wr_go;
    logic wr_store;
    logic wr_ack_q;

    // A read presented in the same cycle wins; the write is simply retried while wr_req stays high.
    assign wr_go    = (state_q == S_READY) && wr_req && !wr_ack_q && !rd_go;
    // The checksum word and anything past DEPTH are acknowledged but never stored.
    assign wr_store = wr_go && ({1'b0, wr_addr} < (DEPTH9 - 9'd1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_go;
        end
    end

    assign wr_ack = wr_ack_q;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_req, wr_addr, wr_data};
    assign wr_ack    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pointer/accumulator updates and the single memory write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        latch_mac = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdat  = 16'h0000;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdat  = init_word(cnt_q);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_ID;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_ID: begin
                if (id_valid) begin
                    latch_mac = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_LOAD_MAC;
                end
            end

            // Two cycles: cnt_q==0 patches word 1, cnt_q==1 patches word 2.
            S_LOAD_MAC: begin
                mem_we = 1'b1;
                if (cnt_q == '0) begin
                    mem_waddr = ADDR_W'(1);
                    mem_wdat  = {mac24_q[23:16], MAC_OUI[7:0]};
                    cnt_d     = ADDR_W'(1);
                end else begin
                    mem_waddr = ADDR_W'(2);
                    mem_wdat  = {mac24_q[7:0], mac24_q[15:8]};
                    cnt_d     = '0;
                    acc_d     = 16'h0000;
                    state_d   = S_CSUM;
                end
            end

            // Sum words 0..DEPTH-2, then spend one more cycle storing the balancing word.
            S_CSUM: begin
                if (cnt_q == LAST) begin
                    mem_we    = 1'b1;
                    mem_waddr = LAST;
                    mem_wdat  = CSUM_TARGET - acc_q;
                    cnt_d     = '0;
                    state_d   = S_READY;
                end else begin
                    acc_d = acc_q + mem[cnt_q];
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_READY: begin
`ifdef NVM_SHADOW_WRITE_EN
                if (wr_store) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr[ADDR_W-1:0];
                    mem_wdat  = wr_data;
                    cnt_d     = '0;
                    acc_d     = 16'h0000;
                    state_d   = S_CSUM;
                end
`endif
            end

            default: begin
                cnt_d   = '0;
                state_d = S_INIT;
            end
        endcase
    end

    // Datapath registers and output flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            acc_q     <= 16'h0000;
            mac24_q   <= 24'h000000;
            mac_valid <= 1'b0;
            rd_ack    <= 1'b0;
            rd_data   <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            // The DNA is taken once; WAIT_ID is never re-entered before the next reset.
            if (latch_mac) begin
                mac24_q <= 24'(id[56:48]) + id[47:24] + id[23:0];
            end
            if ((state_q == S_LOAD_MAC) && (cnt_q != '0)) begin
                mac_valid <= 1'b1;
            end
            rd_ack <= rd_go;
            if (rd_go) begin
                rd_data <= rd_in_range ? mem[rd_addr[ADDR_W-1:0]] : 16'hFFFF;
            end
        end
    end

    // Image storage; every word is rewritten by INIT after reset, so it needs no reset of its own.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    assign mac_address = {MAC_OUI, mac24_q};
    assign busy        = (state_q != S_READY);

endmodule

// File: tb/tb_nvm_shadow.sv
module tb_nvm_shadow;

    localparam int          DEPTH  = 64;
    localparam logic [23:0] OUI    = 24'hEC3F05;
    localparam logic [15:0] TARGET = 16'hBABA;
`ifdef NVM_SHADOW_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [56:0] id = '0;
    logic        id_valid = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [47:0] mac_address;
    logic        mac_valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model [DEPTH];
    logic [23:0] model_mac;
    logic [15:0] rb [DEPTH];
    int          rb_badlat;

    nvm_shadow dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .id          (id),
        .id_valid    (id_valid),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mac_address (mac_address),
        .mac_valid   (mac_valid),
        .busy        (busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [23:0] mac_of(input logic [56:0] v);
        int unsigned s;
        s = 32'(v[56:48]) + 32'(v[47:24]) + 32'(v[23:0]);
        return s[23:0];
    endfunction

    // Expected image: words given by the spec, checksum word balancing the total to TARGET.
    task automatic model_csum();
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i < DEPTH - 1; i++) s = s + model[i];
        model[DEPTH-1] = TARGET - s;
    endtask

    task automatic model_build(input logic [23:0] m);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0;
        model_mac = m;
        model[0]  = {OUI[15:8], OUI[23:16]};
        model[1]  = {m[23:16], OUI[7:0]};
        model[2]  = {m[7:0], m[15:8]};
        model[10] = 16'h6000;
        model[11] = 16'h6120;
        model[12] = 16'hFACE;
        model[13] = 16'h3B00;
        model[14] = 16'h0706;
        model[15] = 16'h1000;
        model[48] = 16'h8000;
        model_csum();
    endtask

    task automatic apply_reset();
        rst_i    = 1'b0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        id_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Releases reset; id_valid/id become valid before edge vd+1. Returns the edge count at which busy fell.
    task automatic boot(input logic [56:0] idv, input int vd, output int fall);
        id_valid = 1'b0;
        id       = 57'({$urandom, $urandom});
        fall     = -1;
        rst_i    = 1'b1;
        for (int n = 1; n <= 500; n++) begin
            if (n - 1 == vd) begin
                id       = idv;
                id_valid = 1'b1;
            end
            tick();
            if (!busy) begin
                fall = n;
                break;
            end
        end
    endtask

    function automatic int exp_fall(input int vd);
        int k;
        k = (vd + 1 > DEPTH + 1) ? vd + 1 : DEPTH + 1;
        return k + 2 + DEPTH;
    endfunction

    task automatic read_one(input logic [7:0] a, output logic [15:0] d, output int lat);
        rd_req  = 1'b1;
        rd_addr = a;
        lat     = -1;
        d       = 16'hxxxx;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (rd_ack) begin
                lat = n;
                d   = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic readback();
        int          lat;
        logic [15:0] d;
        rb_badlat = 0;
        for (int i = 0; i < DEPTH; i++) begin
            read_one(8'(i), d, lat);
            rb[i] = d;
            if (lat != 1) rb_badlat++;
        end
    endtask

    task automatic write_one(input logic [7:0] a, input logic [15:0] d,
                             output int lat, output logic busy_at, output int clen);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        lat     = -1;
        busy_at = 1'bx;
        clen    = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (wr_ack) begin
                lat     = n;
                busy_at = busy;
                break;
            end
        end
        wr_req = 1'b0;
        while (busy && clen < 400) begin
            tick();
            clen++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        n_cmp++; if (mac_valid !== 1'b0) begin n_err++; $display("FAIL reset_mac_valid: got %b want 0", mac_valid); end
        n_cmp++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        n_cmp++; if (mac_address !== {OUI, 24'h0}) begin n_err++; $display("FAIL reset_mac: got %h want %h", mac_address, {OUI, 24'h0}); end
    endtask

    task automatic test_boot_zero();
        int          fall;
        logic [15:0] s;
        apply_reset();
        boot(57'h0, 0, fall);
        model_build(24'h0);
        n_cmp++; if (fall != 2 * DEPTH + 3) begin n_err++; $display("FAIL boot0_latency: got %0d want %0d", fall, 2 * DEPTH + 3); end
        n_cmp++; if (mac_valid !== 1'b1) begin n_err++; $display("FAIL boot0_mac_valid: got %b want 1", mac_valid); end
        n_cmp++; if (mac_address !== 48'hEC3F05000000) begin n_err++; $display("FAIL boot0_mac: got %h want ec3f05000000", mac_address); end
        readback();
        n_cmp++; if (rb_badlat != 0) begin n_err++; $display("FAIL boot0_rd_latency: got %0d slow reads want 0", rb_badlat); end
        n_cmp++; if (rb[0] !== 16'h3FEC) begin n_err++; $display("FAIL boot0_w0: got %h want 3fec", rb[0]); end
        n_cmp++; if (rb[1] !== 16'h0005) begin n_err++; $display("FAIL boot0_w1: got %h want 0005", rb[1]); end
        n_cmp++; if (rb[2] !== 16'h0000) begin n_err++; $display("FAIL boot0_w2: got %h want 0000", rb[2]); end
        n_cmp++; if (rb[63] !== 16'hECD5) begin n_err++; $display("FAIL boot0_w3f: got %h want ecd5", rb[63]); end
        s = 16'h0;
        for (int i = 0; i < DEPTH; i++) begin
            s = s + rb[i];
            n_cmp++; if (rb[i] !== model[i]) begin n_err++; $display("FAIL boot0_word[%0d]: got %h want %h", i, rb[i], model[i]); end
        end
        n_cmp++; if (s !== TARGET) begin n_err++; $display("FAIL boot0_sum: got %h want %h", s, TARGET); end
    endtask

    task automatic test_fixed_id();
        int          fall;
        logic [15:0] s;
        apply_reset();
        boot({9'h001, 24'h000010, 24'h000100}, 0, fall);
        model_build(mac_of({9'h001, 24'h000010, 24'h000100}));
        n_cmp++; if (mac_address !== 48'hEC3F05000111) begin n_err++; $display("FAIL fixed_mac: got %h want ec3f05000111", mac_address); end
        readback();
        n_cmp++; if (rb[1] !== 16'h0005) begin n_err++; $display("FAIL fixed_w1: got %h want 0005", rb[1]); end
        n_cmp++; if (rb[2] !== 16'h1101) begin n_err++; $display("FAIL fixed_w2: got %h want 1101", rb[2]); end
        s = 16'h0;
        for (int i = 0; i < DEPTH; i++) s = s + rb[i];
        n_cmp++; if (s !== TARGET) begin n_err++; $display("FAIL fixed_sum: got %h want %h", s, TARGET); end
    endtask

    task automatic test_random_boots();
        int          fall;
        int          vd;
        logic [56:0] idv;
        logic [15:0] s;
        for (int it = 0; it < 4; it++) begin
            idv = 57'({$urandom, $urandom});
            vd  = (it == 0) ? 0 : int'($urandom_range(0, 120));
            apply_reset();
            boot(idv, vd, fall);
            model_build(mac_of(idv));
            n_cmp++; if (fall != exp_fall(vd)) begin n_err++; $display("FAIL rboot%0d_latency: got %0d want %0d", it, fall, exp_fall(vd)); end
            n_cmp++; if (mac_address !== {OUI, model_mac}) begin n_err++; $display("FAIL rboot%0d_mac: got %h want %h", it, mac_address, {OUI, model_mac}); end
            readback();
            s = 16'h0;
            for (int i = 0; i < DEPTH; i++) begin
                s = s + rb[i];
                n_cmp++; if (rb[i] !== model[i]) begin n_err++; $display("FAIL rboot%0d_word[%0d]: got %h want %h", it, i, rb[i], model[i]); end
            end
            n_cmp++; if (s !== TARGET) begin n_err++; $display("FAIL rboot%0d_sum: got %h want %h", it, s, TARGET); end
        end
    endtask

    task automatic test_id_ignored();
        int          busy_cnt;
        int          lat;
        logic [15:0] d;
        busy_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            id       = 57'({$urandom, $urandom});
            id_valid = n[0];
            tick();
            if (busy) busy_cnt++;
        end
        n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL idign_busy: got %0d busy cycles want 0", busy_cnt); end
        n_cmp++; if (mac_address !== {OUI, model_mac}) begin n_err++; $display("FAIL idign_mac: got %h want %h", mac_address, {OUI, model_mac}); end
        read_one(8'h01, d, lat);
        n_cmp++; if (d !== model[1]) begin n_err++; $display("FAIL idign_w1: got %h want %h", d, model[1]); end
        read_one(8'h02, d, lat);
        n_cmp++; if (d !== model[2]) begin n_err++; $display("FAIL idign_w2: got %h want %h", d, model[2]); end
    endtask

    task automatic test_reads();
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] e;
        int          lat;
        for (int k = 0; k < 20; k++) begin
            a = (k < 6) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 255));
            e = (a < 8'(DEPTH)) ? model[a[5:0]] : 16'hFFFF;
            read_one(a, d, lat);
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL rand_read[%h]: got %h want %h", a, d, e); end
            n_cmp++; if (lat != 1) begin n_err++; $display("FAIL rand_read_lat[%h]: got %0d want 1", a, lat); end
        end
    endtask

    task automatic test_held_read();
        int          acks;
        int          first;
        logic        busy_at;
        logic [15:0] d;
        apply_reset();
        rd_addr  = 8'h80;
        rd_req   = 1'b1;
        id       = 57'h0;
        id_valid = 1'b1;
        tick();
        rst_i    = 1'b1;
        acks     = 0;
        first    = -1;
        busy_at  = 1'bx;
        d        = 16'hxxxx;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (rd_ack) begin
                acks++;
                if (first < 0) begin
                    first   = n;
                    busy_at = busy;
                    d       = rd_data;
                end
            end
            // Requester reacts one cycle late: rd_req is still high on the edge after the ack.
            if (first > 0 && n == first + 1) rd_req = 1'b0;
            if (first > 0 && n >= first + 10) break;
        end
        rd_req = 1'b0;
        model_build(24'h0);
        n_cmp++; if (acks != 1) begin n_err++; $display("FAIL held_ack_count: got %0d want 1", acks); end
        n_cmp++; if (first != 2 * DEPTH + 4) begin n_err++; $display("FAIL held_ack_time: got %0d want %0d", first, 2 * DEPTH + 4); end
        n_cmp++; if (busy_at !== 1'b0) begin n_err++; $display("FAIL held_busy_at_ack: got %b want 0", busy_at); end
        n_cmp++; if (d !== 16'hFFFF) begin n_err++; $display("FAIL held_oob_data: got %h want ffff", d); end
    endtask

    task automatic test_back_to_back();
        int         acks;
        int         bad;
        logic [7:0] a;
        a      = 8'($urandom_range(0, DEPTH - 1));
        acks   = 0;
        bad    = 0;
        rd_addr = a;
        rd_req  = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rd_ack) begin
                acks++;
                if (rd_data !== model[a[5:0]]) bad++;
            end
        end
        rd_req = 1'b0;
        tick();
        tick();
        n_cmp++; if (acks != 5) begin n_err++; $display("FAIL b2b_acks: got %0d want 5", acks); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_data: got %0d bad words want 0", bad); end
    endtask

`ifdef NVM_SHADOW_WRITE_EN
    task automatic test_write();
        int          fall;
        int          lat;
        int          clen;
        logic        busy_at;
        logic [15:0] d;
        logic [15:0] s;
        logic [7:0]  a;
        bit          stores;
        apply_reset();
        boot(57'h0, 0, fall);
        model_build(24'h0);
        write_one(8'h20, 16'h0001, lat, busy_at, clen);
        model[32] = 16'h0001;
        model_csum();
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL wr20_ack_lat: got %0d want 1", lat); end
        n_cmp++; if (busy_at !== 1'b1) begin n_err++; $display("FAIL wr20_busy_at_ack: got %b want 1", busy_at); end
        n_cmp++; if (clen != DEPTH) begin n_err++; $display("FAIL wr20_csum_len: got %0d want %0d", clen, DEPTH); end
        read_one(8'h3F, d, lat);
        n_cmp++; if (d !== 16'hECD4) begin n_err++; $display("FAIL wr20_w3f: got %h want ecd4", d); end
        for (int k = 0; k < 6; k++) begin
            case (k)
                0, 1, 2: a = 8'($urandom_range(0, DEPTH - 2));
                3:       a = 8'(DEPTH - 1);
                default: a = 8'($urandom_range(DEPTH, 255));
            endcase
            d      = 16'($urandom);
            stores = (a < 8'(DEPTH - 1));
            write_one(a, d, lat, busy_at, clen);
            if (stores) begin
                model[a[5:0]] = d;
                model_csum();
            end
            n_cmp++; if (lat != 1) begin n_err++; $display("FAIL rwr%0d_ack_lat: got %0d want 1", k, lat); end
            n_cmp++; if (clen != (stores ? DEPTH : 0)) begin n_err++; $display("FAIL rwr%0d_busy_len: got %0d want %0d", k, clen, stores ? DEPTH : 0); end
        end
        readback();
        s = 16'h0;
        for (int i = 0; i < DEPTH; i++) begin
            s = s + rb[i];
            n_cmp++; if (rb[i] !== model[i]) begin n_err++; $display("FAIL wr_word[%0d]: got %h want %h", i, rb[i], model[i]); end
        end
        n_cmp++; if (s !== TARGET) begin n_err++; $display("FAIL wr_sum: got %h want %h", s, TARGET); end
    endtask
`else
    task automatic test_write();
        int acks;
        int busy_cnt;
        acks     = 0;
        busy_cnt = 0;
        wr_req   = 1'b1;
        wr_addr  = 8'($urandom_range(0, DEPTH - 2));
        wr_data  = 16'($urandom);
        for (int n = 0; n < 10; n++) begin
            tick();
            if (wr_ack) acks++;
            if (busy) busy_cnt++;
        end
        wr_req = 1'b0;
        tick();
        n_cmp++; if (acks != 0) begin n_err++; $display("FAIL nowr_acks: got %0d want 0", acks); end
        n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL nowr_busy: got %0d want 0", busy_cnt); end
        readback();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (rb[i] !== model[i]) begin n_err++; $display("FAIL nowr_word[%0d]: got %h want %h", i, rb[i], model[i]); end
        end
    endtask
`endif

    task automatic test_collision();
        int          rd_t;
        int          wr_t;
        int          busy_cnt;
        int          lat;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] rdv;
        a        = 8'($urandom_range(0, DEPTH - 1));
        rd_t     = -1;
        wr_t     = -1;
        busy_cnt = 0;
        rdv      = 16'hxxxx;
        rd_addr  = a;
        rd_req   = 1'b1;
        wr_addr  = 8'h3F;
        wr_data  = 16'($urandom);
        wr_req   = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (busy) busy_cnt++;
            if (rd_ack && rd_t < 0) begin
                rd_t   = n;
                rdv    = rd_data;
                rd_req = 1'b0;
            end
            if (wr_ack && wr_t < 0) begin
                wr_t   = n;
                wr_req = 1'b0;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();
        n_cmp++; if (rd_t != 1) begin n_err++; $display("FAIL coll_rd_tick: got %0d want 1", rd_t); end
        n_cmp++; if (wr_t != (WR_EN ? 2 : -1)) begin n_err++; $display("FAIL coll_wr_tick: got %0d want %0d", wr_t, WR_EN ? 2 : -1); end
        n_cmp++; if (rdv !== model[a[5:0]]) begin n_err++; $display("FAIL coll_rd_data: got %h want %h", rdv, model[a[5:0]]); end
        n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL coll_busy: got %0d want 0", busy_cnt); end
        read_one(8'h3F, d, lat);
        n_cmp++; if (d !== model[DEPTH-1]) begin n_err++; $display("FAIL coll_w3f: got %h want %h", d, model[DEPTH-1]); end
    endtask

    task automatic test_reset_mid_csum();
        int          fall;
        logic [56:0] idv;
        apply_reset();
        id       = 57'({$urandom, $urandom});
        id_valid = 1'b1;
        rst_i    = 1'b1;
        repeat (100) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        n_cmp++; if (mac_valid !== 1'b1) begin n_err++; $display("FAIL mid_mac_valid_before: got %b want 1", mac_valid); end
        rst_i = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        n_cmp++; if (mac_valid !== 1'b0) begin n_err++; $display("FAIL mid_mac_valid: got %b want 0", mac_valid); end
        n_cmp++; if (mac_address !== {OUI, 24'h0}) begin n_err++; $display("FAIL mid_mac: got %h want %h", mac_address, {OUI, 24'h0}); end
        n_cmp++; if (rd_ack !== 1'b0 || wr_ack !== 1'b0 || rd_data !== 16'h0) begin
            n_err++; $display("FAIL mid_outputs: got rd_ack=%b wr_ack=%b rd_data=%h want 0/0/0000", rd_ack, wr_ack, rd_data);
        end
        tick();
        tick();
        idv = 57'({$urandom, $urandom});
        boot(idv, 0, fall);
        model_build(mac_of(idv));
        n_cmp++; if (fall != 2 * DEPTH + 3) begin n_err++; $display("FAIL mid_reboot_latency: got %0d want %0d", fall, 2 * DEPTH + 3); end
        readback();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (rb[i] !== model[i]) begin n_err++; $display("FAIL mid_word[%0d]: got %h want %h", i, rb[i], model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_zero();
        test_fixed_id();
        test_random_boots();
        test_id_ignored();
        test_reads();
        test_held_read();
        test_back_to_back();
        test_write();
        test_collision();
        test_reset_mid_csum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
